// File: rtl/spi_config_peripheral.sv
// SPI mode-0 write-only target that loads the PWM peripheral's five 8-bit
// control registers. Frames are 16 bits, MSB first: {wr, addr[6:0], data[7:0]}.
// SCLK, COPI and nCS are asynchronous and are synchronised to clk here.
module spi_config_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       cfg_write
);

  localparam logic [4:0] FRAME_BITS = 5'd16;
  localparam logic [4:0] CNT_OVF    = 5'd17;
  localparam logic [6:0] MAX_A      = 7'(MAX_ADDR);
  // Flush window: cycles until the ncs chain shows the real pin level.
  localparam int         FLUSH_CYC  = SYNC_STAGES + 1;
  localparam int         FW         = $clog2(FLUSH_CYC + 1);
  localparam logic [FW-1:0] FLUSH_END = FW'(FLUSH_CYC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // --------------------------------------------------------------------
  // Input synchronisers plus one edge-detect flop on sclk and ncs
  // --------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_d;
  logic                   ncs_d;

  // Multi-flop synchronisers; reset to the bus idle levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ncs_d     <= ncs_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, copi_s, ncs_s;
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign copi_s = copi_sync[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------
  // Capture arming. The ncs chain resets high, so if the pin is held low
  // through reset the chain would show a falling edge once it flushes.
  // A fall is only honoured after ncs has been seen high on a settled chain,
  // which also makes a frame interrupted by reset wait for a fresh select.
  // --------------------------------------------------------------------
  logic [FW-1:0] flush_cnt;
  logic          flush_done;
  logic          armed;

  assign flush_done = (flush_cnt == FLUSH_END);

  // Count out the flush window after reset, then arm on a settled-high ncs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      if (!flush_done) flush_cnt <= flush_cnt + 1'b1;
      if (flush_done && ncs_s) armed <= 1'b1;
    end
  end

  logic sclk_rise, ncs_fall, ncs_rise;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_fall  = armed & ncs_d & ~ncs_s;
  assign ncs_rise  = ncs_s & ~ncs_d;

  // --------------------------------------------------------------------
  // Frame FSM, deserialiser and register file
  // --------------------------------------------------------------------
  state_t      state;
  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt;

  logic       frame_wr;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  assign frame_wr   = shift_reg[15];
  assign frame_addr = shift_reg[14:8];
  assign frame_data = shift_reg[7:0];

  // Single FSM: shifts bits in SHIFT, commits one register write in COMMIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      shift_reg       <= '0;
      bit_cnt         <= '0;
      cfg_write       <= 1'b0;
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
    end else begin
      cfg_write <= 1'b0;
      case (state)
        IDLE: begin
          if (ncs_fall) begin
            state     <= SHIFT;
            shift_reg <= '0;
            bit_cnt   <= '0;
          end
        end
        SHIFT: begin
          // ncs rising wins over a coincident sclk edge.
          if (ncs_rise) begin
            state <= (bit_cnt == FRAME_BITS) ? COMMIT : IDLE;
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[14:0], copi_s};
            if (bit_cnt != CNT_OVF) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        COMMIT: begin
          state <= IDLE;
          // Read frames and out-of-range addresses are silently dropped.
          if (frame_wr && (frame_addr <= MAX_A)) begin
            cfg_write <= 1'b1;
            case (frame_addr)
              7'd0:    en_reg_out_7_0  <= frame_data;
              7'd1:    en_reg_out_15_8 <= frame_data;
              7'd2:    en_reg_pwm_7_0  <= frame_data;
              7'd3:    en_reg_pwm_15_8 <= frame_data;
              7'd4:    pwm_duty_cycle  <= frame_data;
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_config_peripheral.sv
// Self-checking bench for spi_config_peripheral: a bit-banged SPI controller
// drives frames; a reference register model plus a write scoreboard check
// every cfg_write pulse and the register state after each scenario.
module tb_spi_config_peripheral;

  localparam int SS   = 2;
  localparam int HALF = 5;   // sclk half-period in clk cycles (>= SS+1)
  localparam int LAT  = SS + 3;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       cfg_write;

  int   n_checks = 0;
  int   n_pass = 0;
  int   pulse_cnt = 0;
  logic [7:0] exp_regs [0:4];
  wr_t  sb_q [$];

  spi_config_peripheral #(.SYNC_STAGES(SS), .MAX_ADDR(4)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .cfg_write(cfg_write)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] dut_regs();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  function automatic logic [39:0] exp_vec();
    return {exp_regs[4], exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
  endfunction

  function automatic logic [7:0] reg_at(input logic [2:0] a);
    case (a)
      3'd0:    return en_reg_out_7_0;
      3'd1:    return en_reg_out_15_8;
      3'd2:    return en_reg_pwm_7_0;
      3'd3:    return en_reg_pwm_15_8;
      3'd4:    return pwm_duty_cycle;
      default: return 8'hxx;
    endcase
  endfunction

  // Scoreboard: every cfg_write pulse must match the oldest pending write.
  always @(negedge clk) begin
    if (rst_n && cfg_write === 1'b1) begin
      wr_t e;
      pulse_cnt++;
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected_write: got cfg_write=1, expected no pulse");
      end else begin
        e = sb_q.pop_front();
        if (reg_at(e.addr) !== e.data)
          $display("FAIL sb_write_data addr %0d: got %h, expected %h", e.addr, reg_at(e.addr), e.data);
        else
          n_pass++;
      end
    end
  end

  task automatic reset_model();
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    sb_q.delete();
  endtask

  // Shift out bits [first .. first+count-1] of f (index 0 = MSB); bits past 15 are 1.
  task automatic send_bits(input logic [15:0] f, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      copi = (i < 16) ? f[15-i] : 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
  endtask

  // Full frame; the model decides whether it is a valid write. ncs is held
  // high for 'hold' clks afterwards; latency is checked when hold allows.
  task automatic send_frame(input logic [15:0] f, input int nbits, input int hold);
    bit valid;
    int lat;
    valid = (nbits == 16) && f[15] && (f[14:8] <= 7'd4);
    @(negedge clk);
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(f, 0, nbits);
    if (valid) begin
      sb_q.push_back('{addr: f[10:8], data: f[7:0]});
      exp_regs[int'(f[10:8])] = f[7:0];
    end
    ncs = 1'b1;
    lat = 0;
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk);
      #1;
      if (cfg_write === 1'b1 && lat == 0) lat = k;
    end
    if (valid && hold >= LAT) begin
      n_checks++;
      if (lat == 0 || lat > LAT)
        $display("FAIL latency frame %h: got %0d clks, expected 1..%0d", f, lat, LAT);
      else
        n_pass++;
    end
  endtask

  task automatic test_reset();
    reset_model();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (dut_regs() !== 40'h0) $display("FAIL reset_regs: got %h, expected 0", dut_regs());
    else n_pass++;
    n_checks++;
    if (cfg_write !== 1'b0) $display("FAIL reset_cfg_write: got %b, expected 0", cfg_write);
    else n_pass++;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      copi = 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge clk);
      sclk = ~sclk;
    end
    sclk = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (dut_regs() !== 40'h0) $display("FAIL idle_sclk_regs: got %h, expected 0", dut_regs());
    else n_pass++;
    n_checks++;
    if (pulse_cnt !== 0) $display("FAIL idle_sclk_pulses: got %0d, expected 0", pulse_cnt);
    else n_pass++;
  endtask

  task automatic test_out_regs();
    int p0 = pulse_cnt;
    send_frame(16'h80F0, 16, 10);
    send_frame(16'h81CC, 16, 10);
    n_checks++;
    if (dut_regs() !== exp_vec()) $display("FAIL out_regs: got %h, expected %h", dut_regs(), exp_vec());
    else n_pass++;
    n_checks++;
    if ({en_reg_out_15_8, en_reg_out_7_0} !== 16'hCCF0)
      $display("FAIL out_regs_const: got %h, expected ccf0", {en_reg_out_15_8, en_reg_out_7_0});
    else n_pass++;
    n_checks++;
    if (pulse_cnt - p0 != 2 || sb_q.size() != 0)
      $display("FAIL out_pulses: got %0d pulses (%0d pending), expected 2", pulse_cnt - p0, sb_q.size());
    else n_pass++;
  endtask

  task automatic test_pwm_regs();
    int p0 = pulse_cnt;
    send_frame(16'h8480, 16, 10);
    send_frame(16'h8203, 16, 10);
    send_frame(16'h84FF, 16, 10);
    n_checks++;
    if (dut_regs() !== exp_vec()) $display("FAIL pwm_regs: got %h, expected %h", dut_regs(), exp_vec());
    else n_pass++;
    n_checks++;
    if (pwm_duty_cycle !== 8'hFF || en_reg_pwm_7_0 !== 8'h03)
      $display("FAIL pwm_const: got duty %h pwm_lo %h, expected ff 03", pwm_duty_cycle, en_reg_pwm_7_0);
    else n_pass++;
    n_checks++;
    if (pulse_cnt - p0 != 3) $display("FAIL pwm_pulses: got %0d, expected 3", pulse_cnt - p0);
    else n_pass++;
  endtask

  task automatic test_dropped();
    int p0 = pulse_cnt;
    send_frame(16'h8555, 16, 10);
    send_frame(16'h00AA, 16, 10);
    n_checks++;
    if (dut_regs() !== exp_vec()) $display("FAIL dropped_regs: got %h, expected %h", dut_regs(), exp_vec());
    else n_pass++;
    n_checks++;
    if (pulse_cnt != p0) $display("FAIL dropped_pulses: got %0d, expected 0", pulse_cnt - p0);
    else n_pass++;
  endtask

  task automatic test_bad_length();
    int p0 = pulse_cnt;
    send_frame(16'h80F0, 15, 10);
    send_frame(16'h8022, 17, 10);
    n_checks++;
    if (pulse_cnt != p0 || dut_regs() !== exp_vec())
      $display("FAIL bad_len_dropped: got regs %h pulses %0d, expected %h 0", dut_regs(), pulse_cnt - p0, exp_vec());
    else n_pass++;
    send_frame(16'h8011, 16, 10);
    n_checks++;
    if (en_reg_out_7_0 !== 8'h11) $display("FAIL bad_len_recover: got %h, expected 11", en_reg_out_7_0);
    else n_pass++;
    n_checks++;
    if (dut_regs() !== exp_vec()) $display("FAIL bad_len_regs: got %h, expected %h", dut_regs(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int p0 = pulse_cnt;
    @(negedge clk);
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(16'h83FF, 0, 8);
    rst_n = 1'b0;
    reset_model();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (dut_regs() !== 40'h0) $display("FAIL midreset_regs: got %h, expected 0", dut_regs());
    else n_pass++;
    send_bits(16'h83FF, 8, 8);
    ncs = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (dut_regs() !== 40'h0 || pulse_cnt != p0)
      $display("FAIL midreset_tail: got regs %h pulses %0d, expected 0 0", dut_regs(), pulse_cnt - p0);
    else n_pass++;
    send_frame(16'h8377, 16, 10);
    n_checks++;
    if (en_reg_pwm_15_8 !== 8'h77 || dut_regs() !== exp_vec())
      $display("FAIL midreset_next: got %h, expected %h", dut_regs(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int p0 = pulse_cnt;
    send_frame(16'h8155, 16, 2);
    send_frame(16'h8266, 16, 10);
    n_checks++;
    if (dut_regs() !== exp_vec()) $display("FAIL b2b_regs: got %h, expected %h", dut_regs(), exp_vec());
    else n_pass++;
    n_checks++;
    if (pulse_cnt - p0 != 2 || sb_q.size() != 0)
      $display("FAIL b2b_pulses: got %0d pulses (%0d pending), expected 2", pulse_cnt - p0, sb_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_out_regs();
    test_pwm_regs();
    test_dropped();
    test_bad_length();
    test_reset_midframe();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
